// File: rtl/ext_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : ext_mem_bridge
// Brief    : Byte-serial CPU-to-external-memory bridge. It provides a
//            valid/ready request port, a per-beat read timeout and one-hot
//            lane strobes.
// Revision : 1.0 - initial release
// ============================================================================
module ext_mem_bridge #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int BUS_W          = 8,
    parameter int SETUP_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_error,
    output logic                ext_we,
    output logic                ext_re,
    output logic                ext_addr_phase,
    output logic [((ADDR_W/BUS_W) > (DATA_W/BUS_W) ? (ADDR_W/BUS_W) : (DATA_W/BUS_W))-1:0] ext_lane,
    output logic [BUS_W-1:0]    ext_dout,
    output logic [BUS_W-1:0]    ext_oe,
    input  logic [BUS_W-1:0]    ext_din,
    input  logic                ext_in_valid
);

    localparam int c_AB     = ADDR_W / BUS_W;
    localparam int c_DB     = DATA_W / BUS_W;
    localparam int c_LANES  = (c_AB > c_DB) ? c_AB : c_DB;
    localparam int c_BEAT_W = (c_LANES > 1) ? $clog2(c_LANES) : 1;
    localparam int c_WAIT_W = $clog2(SETUP_CYCLES + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RDATA = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_write;
    logic                  r_err;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rdata;
    logic [DATA_W-1:0]     r_rsp_rdata;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_WAIT_W-1:0]   r_wait;
    logic [c_TO_W-1:0]     r_tcnt;

    logic [BUS_W-1:0]      w_addr_byte;
    logic [BUS_W-1:0]      w_data_byte;
    logic [DATA_W-1:0]     w_rdata_cap;
    logic [c_LANES-1:0]    w_lane;
    logic                  w_hold_done;
    logic                  w_last_addr;
    logic                  w_last_data;
    logic                  w_timeout;

    assign w_hold_done = (r_wait == c_WAIT_W'(SETUP_CYCLES - 1));
    assign w_last_addr = (r_beat == c_BEAT_W'(c_AB - 1));
    assign w_last_data = (r_beat == c_BEAT_W'(c_DB - 1));
    assign w_timeout   = (r_tcnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign w_lane      = c_LANES'(1) << r_beat;
    assign rsp_rdata   = r_rsp_rdata;

    // Beat-indexed byte selection; w_rdata_cap is the capture buffer with this beat's byte merged in.
    always_comb begin
        w_addr_byte = '0;
        w_data_byte = '0;
        w_rdata_cap = r_rdata;
        for (int i = 0; i < c_AB; i++) begin
            if (r_beat == c_BEAT_W'(i)) begin
                w_addr_byte = r_addr[i*BUS_W +: BUS_W];
            end
        end
        for (int i = 0; i < c_DB; i++) begin
            if (r_beat == c_BEAT_W'(i)) begin
                w_data_byte = r_wdata[i*BUS_W +: BUS_W];
                w_rdata_cap[i*BUS_W +: BUS_W] = ext_din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus outputs decode from state alone, so an asynchronous reset releases the pins at once.
    always_comb begin
        w_next_state   = r_state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_error      = 1'b0;
        ext_we         = 1'b0;
        ext_re         = 1'b0;
        ext_addr_phase = 1'b0;
        ext_lane       = '0;
        ext_dout       = '0;
        ext_oe         = '0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                ext_addr_phase = 1'b1;
                ext_oe         = '1;
                ext_dout       = w_addr_byte;
                ext_lane       = w_lane;
                ext_we         = r_write;
                ext_re         = ~r_write;
                if (w_hold_done && w_last_addr) begin
                    w_next_state = r_write ? S_WDATA : S_RDATA;
                end
            end
            S_WDATA: begin
                ext_we   = 1'b1;
                ext_oe   = '1;
                ext_dout = w_data_byte;
                ext_lane = w_lane;
                if (w_hold_done && w_last_data) begin
                    w_next_state = S_DONE;
                end
            end
            S_RDATA: begin
                ext_re   = 1'b1;
                ext_lane = w_lane;
                if (ext_in_valid) begin
                    if (w_last_data) begin
                        w_next_state = S_DONE;
                    end
                end else if (w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid    = 1'b1;
                rsp_error    = r_err;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_rdata <= '0;
            r_beat      <= '0;
            r_wait      <= '0;
            r_tcnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                        r_beat  <= '0;
                        r_wait  <= '0;
                        r_tcnt  <= '0;
                    end
                end
                S_ADDR, S_WDATA: begin
                    if (w_hold_done) begin
                        r_wait <= '0;
                        if ((r_state == S_ADDR) ? w_last_addr : w_last_data) begin
                            r_beat <= '0;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                        if (r_state == S_WDATA && w_last_data) begin
                            r_rsp_rdata <= '0;
                            r_err       <= 1'b0;
                        end
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                S_RDATA: begin
                    // A byte arriving on the limit cycle still counts; the timeout only fires without it.
                    if (ext_in_valid) begin
                        r_rdata <= w_rdata_cap;
                        r_tcnt  <= '0;
                        if (w_last_data) begin
                            r_beat      <= '0;
                            r_rsp_rdata <= w_rdata_cap;
                            r_err       <= 1'b0;
                        end else begin
                            r_beat <= r_beat + c_BEAT_W'(1);
                        end
                    end else if (w_timeout) begin
                        r_tcnt      <= '0;
                        r_beat      <= '0;
                        r_rdata     <= '0;
                        r_rsp_rdata <= '0;
                        r_err       <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + c_TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_ext_mem_bridge
// Brief    : Directed self-checking bench for ext_mem_bridge (16/16 and 24/32 widths)
// Revision : 1.0 - initial release
// ============================================================================
module tb_ext_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [15:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        a_rsp_valid, a_rsp_error, a_ext_we, a_ext_re, a_ext_addr_phase;
    logic [1:0]  a_ext_lane;
    logic [7:0]  a_ext_dout, a_ext_oe, a_ext_din;
    logic        a_ext_in_valid;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [23:0] b_req_addr;
    logic [31:0] b_req_wdata, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_error, b_ext_we, b_ext_re, b_ext_addr_phase;
    logic [3:0]  b_ext_lane;
    logic [7:0]  b_ext_dout, b_ext_oe, b_ext_din;
    logic        b_ext_in_valid;

    ext_mem_bridge #(.ADDR_W(16), .DATA_W(16), .BUS_W(8), .SETUP_CYCLES(4), .TIMEOUT_CYCLES(8)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_error(a_rsp_error),
        .ext_we(a_ext_we), .ext_re(a_ext_re), .ext_addr_phase(a_ext_addr_phase),
        .ext_lane(a_ext_lane), .ext_dout(a_ext_dout), .ext_oe(a_ext_oe),
        .ext_din(a_ext_din), .ext_in_valid(a_ext_in_valid)
    );

    ext_mem_bridge #(.ADDR_W(24), .DATA_W(32), .BUS_W(8), .SETUP_CYCLES(4), .TIMEOUT_CYCLES(8)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_error(b_rsp_error),
        .ext_we(b_ext_we), .ext_re(b_ext_re), .ext_addr_phase(b_ext_addr_phase),
        .ext_lane(b_ext_lane), .ext_dout(b_ext_dout), .ext_oe(b_ext_oe),
        .ext_din(b_ext_din), .ext_in_valid(b_ext_in_valid)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Presents one request at a negedge; returns at the negedge of cycle 1 after the accept edge.
    task automatic a_start(input logic wr, input logic [15:0] addr, input logic [15:0] wd);
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
        @(negedge clk);
        a_req_valid = 1'b0;
    endtask

    task automatic b_start(input logic wr, input logic [23:0] addr, input logic [31:0] wd);
        b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
        @(negedge clk);
        b_req_valid = 1'b0;
    endtask

    // Read on DUT A: host answers beat 0 after d0 idle cycles and beat 1 after d1 idle cycles.
    task automatic a_read(input logic [15:0] addr, input int d0, input logic [7:0] b0,
                          input int d1, input logic [7:0] b1,
                          output int lat, output logic [15:0] rdata, output logic err,
                          output int bus_bad);
        lat = 0; rdata = '0; err = 1'b0; bus_bad = 0;
        a_start(1'b0, addr, 16'h0000);
        for (int c = 1; c <= 60; c++) begin
            if (a_rsp_valid) begin
                lat = c; rdata = a_rsp_rdata; err = a_rsp_error;
                break;
            end
            if (c >= 9 && (a_ext_oe != 8'h00 || a_ext_dout != 8'h00 || a_ext_re != 1'b1 || a_ext_addr_phase))
                bus_bad++;
            if (c <= 8 && a_ext_dout != ((c <= 4) ? addr[7:0] : addr[15:8]))
                bus_bad++;
            a_ext_in_valid = (c == 9 + d0) || (c == 10 + d0 + d1);
            a_ext_din      = (c == 9 + d0) ? b0 : ((c == 10 + d0 + d1) ? b1 : 8'h00);
            @(negedge clk);
        end
        a_ext_in_valid = 1'b0;
        a_ext_din      = 8'h00;
        @(negedge clk);
    endtask

    logic [7:0]  wb [4];
    logic [7:0]  bb [7];
    int          beat, lat, bus_bad, pulses, ready_bad, late_rsp;
    logic [15:0] rdata;
    logic        err;

    initial begin
        reset = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wdata = '0; a_ext_din = '0; a_ext_in_valid = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wdata = '0; b_ext_din = '0; b_ext_in_valid = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", a_req_ready, 1);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rdata", a_rsp_rdata, 0);
        check("rst_oe", a_ext_oe, 0);
        check("rst_bus", {a_ext_we, a_ext_re, a_ext_addr_phase, a_ext_lane, a_ext_dout}, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_ready", a_req_ready, 1);

        // Write BEEF/1234; a stray ext_in_valid outside RDATA must not disturb anything
        wb = '{8'hEF, 8'hBE, 8'h34, 8'h12};
        a_ext_in_valid = 1'b1; a_ext_din = 8'h99;
        a_start(1'b1, 16'hBEEF, 16'h1234);
        for (int c = 1; c <= 17; c++) begin
            if (c <= 16) begin
                beat = (c - 1) / 4;
                check("wr_dout", a_ext_dout, wb[beat]);
                check("wr_lane", a_ext_lane, (beat % 2 == 0) ? 32'h1 : 32'h2);
                check("wr_addr_phase", a_ext_addr_phase, (c <= 8) ? 32'h1 : 32'h0);
                check("wr_oe", a_ext_oe, 32'hFF);
                check("wr_we_re", {a_ext_we, a_ext_re}, 32'h2);
                check("wr_ready", a_req_ready, 0);
            end
            check("wr_rsp_valid", a_rsp_valid, (c == 17) ? 32'h1 : 32'h0);
            if (c == 17) begin
                check("wr_rsp_error", a_rsp_error, 0);
                check("wr_rsp_rdata", a_rsp_rdata, 0);
                check("wr_done_release", {a_ext_we, a_ext_oe, a_ext_lane, a_ext_dout}, 0);
            end
            @(negedge clk);
        end
        a_ext_in_valid = 1'b0;
        check("wr_post_valid", a_rsp_valid, 0);
        check("wr_post_ready", a_req_ready, 1);

        // Read 00FF, host answers CD then AB, each after 3 idle cycles
        a_read(16'h00FF, 3, 8'hCD, 3, 8'hAB, lat, rdata, err, bus_bad);
        check("rd_latency", lat, 17);
        check("rd_rdata", rdata, 16'hABCD);
        check("rd_error", err, 0);
        check("rd_bus", bus_bad, 0);
        check("rd_hold_rdata", a_rsp_rdata, 16'hABCD);
        check("rd_pulse_width", a_rsp_valid, 0);

        // Minimum read latency: AB*SETUP + DB + 1 = 11
        a_read(16'h1357, 0, 8'h11, 0, 8'h22, lat, rdata, err, bus_bad);
        check("rdmin_latency", lat, 11);
        check("rdmin_rdata", rdata, 16'h2211);
        check("rdmin_bus", bus_bad, 0);

        // Host silent on beat 1: 8 idle cycles then error with zeroed data
        a_read(16'h4242, 0, 8'h55, 999, 8'h00, lat, rdata, err, bus_bad);
        check("to_latency", lat, 18);
        check("to_error", err, 1);
        check("to_rdata", rdata, 0);
        check("to_bus", bus_bad, 0);
        check("to_err_drop", a_rsp_error, 0);

        // Valid on the last permitted cycle of beat 1 wins over the timeout
        a_read(16'h0F0F, 0, 8'h66, 7, 8'h77, lat, rdata, err, bus_bad);
        check("edge1_latency", lat, 18);
        check("edge1_error", err, 0);
        check("edge1_rdata", rdata, 16'h7766);

        // Same on beat 0
        a_read(16'hF0F0, 7, 8'h88, 0, 8'h99, lat, rdata, err, bus_bad);
        check("edge0_latency", lat, 18);
        check("edge0_error", err, 0);
        check("edge0_rdata", rdata, 16'h9988);

        // req_valid held through a busy write: one response, re-accept only after DONE
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h5A5A; a_req_wdata = 16'hC3C3;
        @(negedge clk);
        pulses = 0; ready_bad = 0;
        for (int c = 1; c <= 18; c++) begin
            if (a_rsp_valid) pulses++;
            if (c <= 17 && a_req_ready) ready_bad++;
            if (c == 17) check("busy_done", a_rsp_valid, 1);
            if (c == 18) check("busy_ready_after", a_req_ready, 1);
            @(negedge clk);
        end
        check("busy_pulses", pulses, 1);
        check("busy_ready_low", ready_bad, 0);
        check("busy_reaccept", a_ext_addr_phase, 1);
        check("busy_reaccept_ready", a_req_ready, 0);
        a_req_valid = 1'b0;
        late_rsp = 0;
        for (int c = 19; c <= 40; c++) begin
            if (a_rsp_valid) begin late_rsp = c; break; end
            @(negedge clk);
        end
        check("busy_second_latency", late_rsp, 35);
        @(negedge clk);

        // DUT B: reset pulled during WDATA releases the bus immediately, no response
        b_start(1'b1, 24'h0F0E0D, 32'h11223344);
        repeat (14) @(negedge clk);
        check("b_mid_wdata", {b_ext_we, b_ext_addr_phase, b_ext_oe}, 32'h2FF);
        #2 reset = 1'b0;
        #1;
        check("b_rst_oe", b_ext_oe, 0);
        check("b_rst_bus", {b_ext_we, b_ext_re, b_ext_lane, b_ext_dout}, 0);
        check("b_rst_ready", b_req_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (b_rsp_valid) pulses++;
            @(negedge clk);
        end
        check("b_rst_no_rsp", pulses, 0);

        // DUT B rerun: 3 address beats, 4 data beats, lanes 0001..1000
        bb = '{8'hC3, 8'hB2, 8'hA1, 8'h07, 8'hF6, 8'hE5, 8'hD4};
        b_start(1'b1, 24'hA1B2C3, 32'hD4E5F607);
        for (int c = 1; c <= 29; c++) begin
            if (c <= 28) begin
                beat = (c - 1) / 4;
                check("b_dout", b_ext_dout, bb[beat]);
                check("b_lane", b_ext_lane, (beat < 3) ? (32'h1 << beat) : (32'h1 << (beat - 3)));
                check("b_addr_phase", b_ext_addr_phase, (c <= 12) ? 32'h1 : 32'h0);
            end
            check("b_rsp_valid", b_rsp_valid, (c == 29) ? 32'h1 : 32'h0);
            if (c == 29) check("b_rsp", {b_rsp_error, b_rsp_rdata}, 0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
- Parametrised byte-serial bridge between the CPU memory port and the off-chip memory host over a narrow bidirectional bus.
- Widths are generic: address, data, external bus and setup hold are all parameters.
- Adds three things the fixed-width controller lacks: a valid/ready request handshake, a per-beat read timeout with an error response, and explicit one-hot lane strobes.
- Sits between the core load/store unit and the chip uio pins.

Parameters:
- ADDR_W, 16: request address width; must be a multiple of BUS_W.
- DATA_W, 16: request data width; must be a multiple of BUS_W.
- BUS_W, 8: external data bus width.
- SETUP_CYCLES, 4: cycles each driven beat is held; must be ≥1.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for ext_in_valid on each read beat; must be ≥1.

Derived values:
- AB = ADDR_W/BUS_W (address beats).
- DB = DATA_W/BUS_W (data beats).
- LANES = max(AB, DB).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  bridge can accept a request.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  request address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
- rsp_error  output  1  read timed out, valid with rsp_valid.
- ext_we  output  1  write transaction in progress.
- ext_re  output  1  read transaction in progress.
- ext_addr_phase  output  1  bus currently carries address bytes.
- ext_lane  output  LANES  one-hot beat index being driven or awaited.
- ext_dout  output  BUS_W  outbound byte.
- ext_oe  output  BUS_W  per-pin output enable (1 = drive).
- ext_din  input  BUS_W  inbound byte.
- ext_in_valid  input  1  host presents a read byte this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE.
  - req_ready=1.
  - rsp_valid=0, rsp_error=0, rsp_rdata=0.
  - ext_we=0, ext_re=0, ext_addr_phase=0.
  - ext_lane=0, ext_dout=0, ext_oe=0.
  - All counters are cleared.
  - A reset mid-transaction abandons it: no rsp_valid, bus released the same instant.
- State machine: IDLE, ADDR, WDATA, RDATA, DONE.
- IDLE:
  - req_ready=1; all ext outputs are at their reset values.
  - The request is accepted on the edge where req_valid && req_ready.
  - On acceptance, latch req_addr, req_wdata and req_write; set beat=0 and wait=0; go to ADDR.
  - req_ready=0 in every other state; requests presented then are ignored, not queued.
- ADDR:
  - ext_addr_phase=1, ext_oe all ones.
  - ext_dout = latched address byte[beat], least significant byte first; ext_lane = 1<<beat.
  - ext_we = latched write, ext_re = not write.
  - Each beat is held SETUP_CYCLES cycles.
  - After beat AB-1, go to WDATA (write) or RDATA (read), with beat=0.
- WDATA:
  - ext_addr_phase=0.
  - ext_dout = latched data byte[beat], ext_lane = 1<<beat, ext_oe all ones.
  - Each beat is held SETUP_CYCLES cycles.
  - After beat DB-1, go to DONE.
- RDATA:
  - ext_oe=0; ext_dout=0; ext_lane = 1<<beat; ext_re=1.
  - The timeout counter starts at 0 for each beat.
  - When ext_in_valid=1: capture ext_din into rdata byte[beat], then advance the beat.
  - After capturing beat DB-1, go to DONE with the error flag clear.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ext_in_valid, go to DONE with the error flag set and the captured rdata discarded (forced to 0).
  - ext_in_valid in the same cycle as the timeout limit: the valid wins (the byte is captured, no error).
  - ext_in_valid in any state other than RDATA is ignored.
- DONE (one cycle):
  - rsp_valid=1; rsp_rdata = captured data (0 for writes and for errors); rsp_error = flag.
  - All ext outputs are released to their reset values.
  - Next state is IDLE; rsp_valid then drops to 0.
  - rsp_rdata holds its value until the next DONE.
- Write latency: rsp_valid is high exactly (AB+DB)*SETUP_CYCLES+1 cycles after the accept edge, i.e. 17 cycles with the defaults.
- Read latency is data-dependent; the minimum is AB*SETUP_CYCLES+DB+1 cycles.
- Counters:
  - The wait counter is clog2(SETUP_CYCLES+1) bits wide.
  - The timeout counter is clog2(TIMEOUT_CYCLES+1) bits wide.
  - Neither counter wraps; both are cleared at every beat change.

Test Plan:
1. Write, defaults, addr=0xBEEF, wdata=0x1234:
   - ext_dout sequence EF,BE,34,12, each held 4 cycles.
   - ext_lane sequence 01,10,01,10 (binary); ext_addr_phase high for the first 8 cycles.
   - rsp_valid 17 cycles after accept; rsp_error=0.
2. Read addr=0x00FF with host replying ext_din=0xCD then 0xAB, each after 3 cycles:
   - ext_oe=0 during RDATA.
   - rsp_rdata=0xABCD, rsp_error=0.
3. Read with the host silent on beat 1, TIMEOUT_CYCLES=8:
   - rsp_valid after 8 idle cycles on beat 1.
   - rsp_error=1, rsp_rdata=0x0000.
4. ext_in_valid asserted on exactly the final timeout cycle:
   - The byte is captured and rsp_error=0.
5. req_valid held during a busy write:
   - req_ready=0 throughout; exactly one rsp_valid.
   - A new request is accepted only in the cycle after DONE.
6. Reset pulled low mid-WDATA, then ADDR_W=24, DATA_W=32 rerun:
   - On reset: immediate ext_oe=0, no response.
   - On the rerun: 3 address beats and 4 data beats, with ext_lane walking 0001 to 1000.
